// File: rtl/conv3x3_mode_kernel.sv
// Streaming 3x3 convolution over a raster image with four selectable kernels.
// Two line buffers feed a 3x3 window; a 3-stage pipeline produces interior pixels.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a sof pixel; other valid pixels are dropped
// ACTIVE | frame in progress; every valid pixel is accepted
// DRAIN  | last pixel taken, pipeline emptying; only a new sof is accepted
module conv3x3_mode_kernel #(
  parameter int WIDTH     = 8,
  parameter int COLS      = 640,
  parameter int ROWS      = 480,
  parameter int LINE_BITS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_in_valid,
  input  logic             data_in_sof,
  output logic [WIDTH-1:0] data_out,
  output logic             data_out_valid,
  output logic             data_out_done
);

  localparam int ACC_W = WIDTH + 5;
  localparam int IDX_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [LINE_BITS-1:0] COL_LAST = LINE_BITS'(COLS - 1);
  localparam logic [LINE_BITS-1:0] ROW_LAST = LINE_BITS'(ROWS - 1);

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  localparam acc_t PIX_MAX = acc_t'((1 << WIDTH) - 1);

  state_t               state;
  logic [LINE_BITS-1:0] col_cnt, row_cnt, pix_col, pix_row;
  logic                 accept, last_pix, interior;
  logic [IDX_W-1:0]     col_idx;
  logic [1:0]           mode_q, mode_w, mode_s1, mode_s2;
  logic                 v_w, v_s1, v_s2, d_w, d_s1, d_s2;

  logic [WIDTH-1:0]     lb0 [COLS];
  logic [WIDTH-1:0]     lb1 [COLS];
  logic [WIDTH-1:0]     win [3][3];

  acc_t centre, cross_sum, corner_sum;
  acc_t p_c_n, p_x_n, p_d_n, p_c, p_x, p_d;
  acc_t sum_s2, scaled;
  logic [WIDTH-1:0] result;

  // A sof pixel is always (0,0), whatever the counters say.
  always_comb begin
    accept   = data_in_valid && (data_in_sof || state == ACTIVE);
    pix_col  = data_in_sof ? '0 : col_cnt;
    pix_row  = data_in_sof ? '0 : row_cnt;
    last_pix = (pix_row == ROW_LAST) && (pix_col == COL_LAST);
    interior = (pix_row >= LINE_BITS'(2)) && (pix_col >= LINE_BITS'(2));
    col_idx  = pix_col[IDX_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      col_cnt        <= '0;
      row_cnt        <= '0;
      mode_q         <= '0;
      v_w            <= 1'b0;
      v_s1           <= 1'b0;
      v_s2           <= 1'b0;
      d_w            <= 1'b0;
      d_s1           <= 1'b0;
      d_s2           <= 1'b0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      data_out_done  <= 1'b0;
    end else begin
      v_w            <= accept && interior;
      d_w            <= accept && last_pix;
      v_s1           <= v_w;
      d_s1           <= d_w;
      v_s2           <= v_s1;
      d_s2           <= d_s1;
      data_out_valid <= v_s2;
      data_out_done  <= d_s2;
      if (v_s2) data_out <= result;

      if (accept) begin
        if (data_in_sof) mode_q <= mode;
        if (pix_col == COL_LAST) begin
          col_cnt <= '0;
          row_cnt <= pix_row + 1'b1;
        end else begin
          col_cnt <= pix_col + 1'b1;
          row_cnt <= pix_row;
        end
      end

      case (state)
        IDLE:    if (accept) state <= ACTIVE;
        ACTIVE:  if (accept && last_pix) state <= DRAIN;
        DRAIN: begin
          if (accept) state <= ACTIVE;
          else if (!(v_w || v_s1 || v_s2)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Window columns shift left; the new right column is {row-2, row-1, row}.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col_idx] <= lb0[col_idx];
      lb0[col_idx] <= data_in;
      for (int i = 0; i < 3; i++) begin
        win[i][0] <= win[i][1];
        win[i][1] <= win[i][2];
      end
      win[0][2] <= lb1[col_idx];
      win[1][2] <= lb0[col_idx];
      win[2][2] <= data_in;
      mode_w    <= data_in_sof ? mode : mode_q;
    end
    p_c     <= p_c_n;
    p_x     <= p_x_n;
    p_d     <= p_d_n;
    mode_s1 <= mode_w;
    sum_s2  <= p_c + p_x + p_d;
    mode_s2 <= mode_s1;
  end

  // Every kernel is symmetric, so only centre, edge and corner weights differ.
  always_comb begin
    centre     = acc_t'(win[1][1]);
    cross_sum  = acc_t'(win[0][1]) + acc_t'(win[1][0]) + acc_t'(win[1][2]) + acc_t'(win[2][1]);
    corner_sum = acc_t'(win[0][0]) + acc_t'(win[0][2]) + acc_t'(win[2][0]) + acc_t'(win[2][2]);
    p_c_n = centre;
    p_x_n = '0;
    p_d_n = '0;
    case (mode_w)
      2'd1: begin
        p_c_n = (centre <<< 2) + centre;
        p_x_n = -cross_sum;
      end
      2'd2: begin
        p_c_n = centre <<< 2;
        p_x_n = cross_sum <<< 1;
        p_d_n = corner_sum;
      end
      2'd3: begin
        p_c_n = centre <<< 3;
        p_x_n = -cross_sum;
        p_d_n = -corner_sum;
      end
      default: ;
    endcase
  end

  always_comb begin
    scaled = sum_s2;
    if (mode_s2 == 2'd2) scaled = (sum_s2 + acc_t'(8)) >>> 4;
    else if (mode_s2 == 2'd3 && sum_s2 < 0) scaled = -sum_s2;
    if (scaled < 0) result = '0;
    else if (scaled > PIX_MAX) result = '1;
    else result = scaled[WIDTH-1:0];
  end

endmodule

// File: tb/tb_conv3x3_mode_kernel.sv
// Directed and scoreboard checks for conv3x3_mode_kernel on a 6x5 frame.
module tb_conv3x3_mode_kernel;
  localparam int WIDTH = 8, COLS = 6, ROWS = 5, LINE_BITS = 10;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       mode;
  logic [WIDTH-1:0] data_in;
  logic             data_in_valid, data_in_sof;
  logic [WIDTH-1:0] data_out;
  logic             data_out_valid, data_out_done;

  conv3x3_mode_kernel #(.WIDTH(WIDTH), .COLS(COLS), .ROWS(ROWS), .LINE_BITS(LINE_BITS)) dut (
    .clk(clk), .reset(reset), .mode(mode), .data_in(data_in),
    .data_in_valid(data_in_valid), .data_in_sof(data_in_sof),
    .data_out(data_out), .data_out_valid(data_out_valid), .data_out_done(data_out_done)
  );

  always #5 clk = ~clk;

  typedef struct {int data; int done; int cyc;} exp_t;
  typedef struct {int pat; int md; int idx; int want;} vec_t;

  exp_t exp_q[$];
  exp_t e_cur;
  int   frame_out[$];
  vec_t vecs[$];
  int   img[ROWS][COLS];
  int   cyc = 0, checks = 0, errors = 0, done_cnt = 0, out_cnt = 0, last_out = 0;
  int   fr_pat[7] = '{0, 0, 0, 0, 1, 1, 2};
  int   fr_md[7]  = '{0, 1, 2, 3, 3, 2, 1};
  int   rmodes[4] = '{1, 2, 3, 0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Output monitor and scoreboard
  always @(negedge clk) begin
    if (!reset) last_out = 0;
    else begin
      if (data_out_done) begin
        done_cnt++;
        check("done_with_valid", int'(data_out_valid), 1);
      end
      if (data_out_valid) begin
        out_cnt++;
        frame_out.push_back(int'(data_out));
        last_out = int'(data_out);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0d, expected no output", data_out);
        end else begin
          e_cur = exp_q.pop_front();
          check("out_data", int'(data_out), e_cur.data);
          check("out_done", int'(data_out_done), e_cur.done);
          check("out_cycle", cyc, e_cur.cyc);
        end
      end else begin
        check("hold_when_idle", int'(data_out), last_out);
      end
    end
  end

  function automatic int exp_pix(input int r, input int c, input int md);
    int s = 0;
    int w, v;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        if (dr == 0 && dc == 0)      w = (md == 0) ? 1 : (md == 1) ? 5 : (md == 2) ? 4 : 8;
        else if (dr == 0 || dc == 0) w = (md == 0) ? 0 : (md == 2) ? 2 : -1;
        else                         w = (md <= 1) ? 0 : (md == 2) ? 1 : -1;
        s += w * img[r+dr][c+dc];
      end
    if (md == 2)      v = (s + 8) / 16;
    else if (md == 3) v = (s < 0) ? -s : s;
    else              v = s;
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return v;
  endfunction

  function automatic void add_vec(input int pat, input int md, input int idx, input int want);
    vec_t v;
    v.pat = pat; v.md = md; v.idx = idx; v.want = want;
    vecs.push_back(v);
  endfunction

  task automatic fill(input int pat);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        case (pat)
          0:       img[r][c] = 100;
          1:       img[r][c] = (r == 2 && c == 2) ? 20 : 0;
          2:       img[r][c] = (r == 2 && c == 2) ? 255 : 0;
          default: img[r][c] = $urandom_range(255);
        endcase
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      data_in_valid = 1'b0;
      data_in_sof   = 1'b0;
    end
  endtask

  task automatic send_pixel(input int px, input bit sof, input int md, output int acc);
    @(negedge clk);
    data_in       = px[WIDTH-1:0];
    data_in_sof   = sof;
    data_in_valid = 1'b1;
    mode          = md[1:0];
    @(posedge clk);
    #1 acc = cyc;
  endtask

  task automatic send_frame(input int md, input int gap, input int npix, input bit jitter);
    int acc, r, c, g, m;
    exp_t e;
    for (int i = 0; i < npix; i++) begin
      r = i / COLS;
      c = i % COLS;
      g = 0;
      while (g < 6 && $urandom_range(99) < gap) begin
        idle(1);
        g++;
      end
      m = (i == 0 || !jitter) ? md : $urandom_range(3);
      send_pixel(img[r][c], i == 0, m, acc);
      if (r >= 2 && c >= 2) begin
        e.data = exp_pix(r - 1, c - 1, md);
        e.done = (r == ROWS - 1 && c == COLS - 1) ? 1 : 0;
        e.cyc  = acc + 3;
        exp_q.push_back(e);
      end
    end
  endtask

  initial begin
    int d0, o0, got, acc, wait_cnt;
    reset = 1'b0; mode = '0; data_in = '0; data_in_valid = 1'b0; data_in_sof = 1'b0;

    // {pattern, mode, output ordinal (raster over interior), expected}
    add_vec(0, 0, 0, 100);  add_vec(0, 0, 11, 100);
    add_vec(0, 1, 0, 100);  add_vec(0, 1, 5, 100);
    add_vec(0, 2, 6, 100);  add_vec(0, 2, 11, 100);
    add_vec(0, 3, 3, 0);    add_vec(0, 3, 8, 0);
    add_vec(1, 3, 5, 160);
    add_vec(1, 3, 0, 20);   add_vec(1, 3, 1, 20);  add_vec(1, 3, 2, 20);  add_vec(1, 3, 4, 20);
    add_vec(1, 3, 6, 20);   add_vec(1, 3, 8, 20);  add_vec(1, 3, 9, 20);  add_vec(1, 3, 10, 20);
    add_vec(1, 3, 3, 0);    add_vec(1, 3, 7, 0);   add_vec(1, 3, 11, 0);
    add_vec(1, 2, 5, 5);    add_vec(1, 2, 1, 3);   add_vec(1, 2, 0, 1);   add_vec(1, 2, 3, 0);
    add_vec(2, 1, 5, 255);  add_vec(2, 1, 1, 0);   add_vec(2, 1, 4, 0);   add_vec(2, 1, 6, 0);
    add_vec(2, 1, 9, 0);    add_vec(2, 1, 0, 0);

    repeat (3) @(posedge clk);
    #3;
    check("reset_data_out", int'(data_out), 0);
    check("reset_valid", int'(data_out_valid), 0);
    check("reset_done", int'(data_out_done), 0);
    @(posedge clk);
    #2 reset = 1'b1;

    for (int fi = 0; fi < 7; fi++) begin
      fill(fr_pat[fi]);
      frame_out.delete();
      d0 = done_cnt;
      send_frame(fr_md[fi], 0, ROWS * COLS, 1'b0);
      idle(6);
      check($sformatf("frame%0d_outputs", fi), frame_out.size(), 12);
      check($sformatf("frame%0d_done", fi), done_cnt - d0, 1);
      for (int vi = 0; vi < vecs.size(); vi++)
        if (vecs[vi].pat == fr_pat[fi] && vecs[vi].md == fr_md[fi]) begin
          got = (vecs[vi].idx < frame_out.size()) ? frame_out[vecs[vi].idx] : -1;
          check($sformatf("vec_p%0d_m%0d_i%0d", vecs[vi].pat, vecs[vi].md, vecs[vi].idx), got, vecs[vi].want);
        end
    end

    // Random images, ~50% input gaps, mode wiggling after sof
    for (int k = 0; k < 4; k++) begin
      fill(3);
      d0 = done_cnt;
      o0 = out_cnt;
      send_frame(rmodes[k], 50, ROWS * COLS, 1'b1);
      if (k == 0) repeat (3) send_pixel($urandom_range(255), 1'b0, 0, acc);
      idle(6);
      check($sformatf("rand%0d_outputs", k), out_cnt - o0, 12);
      check($sformatf("rand%0d_done", k), done_cnt - d0, 1);
    end

    // Abort at (3,2): four outputs from the aborted frame, no done for it
    fill(3);
    d0 = done_cnt; o0 = out_cnt;
    send_frame(2, 0, 20, 1'b0);
    send_frame(3, 0, ROWS * COLS, 1'b0);
    idle(6);
    check("abort_outputs", out_cnt - o0, 16);
    check("abort_done", done_cnt - d0, 1);

    // sof immediately after the last pixel of the previous frame
    fill(3);
    d0 = done_cnt; o0 = out_cnt;
    send_frame(1, 0, ROWS * COLS, 1'b0);
    fill(3);
    send_frame(3, 0, ROWS * COLS, 1'b0);
    idle(6);
    check("b2b_outputs", out_cnt - o0, 24);
    check("b2b_done", done_cnt - d0, 2);

    // One-cycle reset mid-frame with outputs in flight
    fill(0);
    send_frame(0, 0, 17, 1'b0);
    idle(2);
    @(posedge clk);
    #2 reset = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_data_out", int'(data_out), 0);
    check("midrst_valid", int'(data_out_valid), 0);
    check("midrst_done", int'(data_out_done), 0);
    @(posedge clk);
    #2 reset = 1'b1;
    o0 = out_cnt;
    repeat (10) send_pixel($urandom_range(255), 1'b0, 0, acc);
    idle(6);
    check("post_reset_no_output", out_cnt - o0, 0);

    fill(0);
    frame_out.delete();
    d0 = done_cnt;
    send_frame(1, 0, ROWS * COLS, 1'b0);
    idle(6);
    check("recover_outputs", frame_out.size(), 12);
    check("recover_done", done_cnt - d0, 1);
    got = (frame_out.size() > 0) ? frame_out[0] : -1;
    check("recover_first", got, 100);

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
